jtpang_objdma: RTL and testbench

Sequences the object-table DMA. It copies the sprite attribute table from CPU work RAM into the video object buffer.
A CPU write pulses dma_go. The block then requests the Z80 bus, waits for the grant, streams LEN bytes using a one-cycle read pipeline, and releases the bus.
It sits between the CPU bus signals (busrq/busak_n) and jtpang_video's object buffer write port, all in the clk domain.

---
 rtl/jtpang_dma_pkg.sv | 17 +
 rtl/jtpang_dma_wdog.sv | 35 +++
 rtl/jtpang_objdma.sv | 174 +++++++++++++++++
 tb/tb_jtpang_objdma.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtpang_dma_pkg.sv
// Shared types and constants for the object-table DMA sequencer.
package jtpang_dma_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        XFER = 3'd2,
        LAST = 3'd3,
        REL  = 3'd4
    } dma_state_t;

    localparam int unsigned DEF_AW     = 12;
    localparam int unsigned DEF_LEN    = 512;
    localparam int unsigned WDOG_W     = 10;
    localparam int unsigned WDOG_LIMIT = 1023;

endpackage

// File: rtl/jtpang_dma_wdog.sv
// Bus-grant watchdog: counts cen ticks spent waiting in REQ and flags a
// sticky error when the grant never arrives.
module jtpang_dma_wdog
    import jtpang_dma_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic cen,
    input  logic run,
    input  logic grant,
    output logic expire_c,
    output logic err
);

    logic [WDOG_W-1:0] cnt;

    // Fires on the tick that would make WDOG_LIMIT ungranted ticks.
    assign expire_c = run && cen && !grant && (cnt == WDOG_W'(WDOG_LIMIT - 1));

    // Tick counter cleared outside REQ; error stays set until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            if (!run) begin
                cnt <= '0;
            end else if (cen && !grant) begin
                cnt <= expire_c ? '0 : cnt + WDOG_W'(1);
            end
            err <= err | expire_c;
        end
    end

endmodule

// File: rtl/jtpang_objdma.sv
// Object-table DMA: requests the Z80 bus, copies LEN bytes from work RAM
// into the object buffer through a one-tick read pipeline, releases the bus.
// Optional macro: JTPANG_DMA_WATCHDOG_EN adds a grant-timeout watchdog.
module jtpang_objdma
    import jtpang_dma_pkg::*;
#(
    parameter int unsigned AW       = DEF_AW,
    parameter int unsigned LEN      = DEF_LEN,
    parameter int unsigned SRC_BASE = 0
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic          dma_go,
    input  logic          busak_n,
    output logic          busrq,
    output logic [AW-1:0] dma_addr,
    input  logic [7:0]    dma_din,
    output logic [AW-1:0] buf_addr,
    output logic [7:0]    buf_dout,
    output logic          buf_we,
    output logic          busy,
    output logic          dma_err
);

    localparam int unsigned    CW        = AW + 1;
    localparam logic [CW-1:0]  CNT_LAST  = CW'(LEN - 1);
    localparam logic [AW-1:0]  SRC_START = AW'(SRC_BASE);
    localparam logic [AW-1:0]  BUF_LAST  = AW'(LEN - 1);

    dma_state_t    state, state_nx;
    logic          pending, pending_nx;
    logic          busrq_nx, busy_nx, buf_we_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [AW-1:0] dma_addr_nx, buf_addr_nx;
    logic [7:0]    buf_dout_nx;
    logic [7:0]    hold_q, hold_q_nx;
    logic          hold_vld, hold_vld_nx;
    logic [7:0]    rd_data_c;
    logic          wd_expire_c;

`ifdef JTPANG_DMA_WATCHDOG_EN
    jtpang_dma_wdog u_wdog (
        .clk      (clk),
        .rst      (rst),
        .cen      (cen),
        .run      (state == REQ),
        .grant    (!busak_n),
        .expire_c (wd_expire_c),
        .err      (dma_err)
    );
`else
    assign wd_expire_c = 1'b0;
    assign dma_err     = 1'b0;
`endif

    // While stalled the source address is frozen one ahead of the byte
    // owed to the buffer, so the first stalled tick parks that byte here.
    assign rd_data_c = hold_vld ? hold_q : dma_din;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state and next-output logic; the FSM only moves on cen ticks.
    always_comb begin
        state_nx    = state;
        pending_nx  = pending | dma_go;
        busrq_nx    = busrq;
        busy_nx     = busy;
        buf_we_nx   = 1'b0;
        cnt_nx      = cnt;
        dma_addr_nx = dma_addr;
        buf_addr_nx = buf_addr;
        buf_dout_nx = buf_dout;
        hold_q_nx   = hold_q;
        hold_vld_nx = hold_vld;
        if (cen) begin
            case (state)
                IDLE: begin
                    if (pending) begin
                        pending_nx  = dma_go;
                        busrq_nx    = 1'b1;
                        busy_nx     = 1'b1;
                        cnt_nx      = '0;
                        dma_addr_nx = SRC_START;
                        hold_vld_nx = 1'b0;
                        state_nx    = REQ;
                    end
                end
                REQ: begin
                    if (!busak_n) begin
                        state_nx = XFER;
                    end else if (wd_expire_c) begin
                        busrq_nx = 1'b0;
                        busy_nx  = 1'b0;
                        state_nx = IDLE;
                    end
                end
                XFER: begin
                    if (busak_n) begin
                        if (!hold_vld) begin
                            hold_q_nx   = dma_din;
                            hold_vld_nx = 1'b1;
                        end
                    end else begin
                        if (cnt != '0) begin
                            buf_we_nx   = 1'b1;
                            buf_addr_nx = AW'(cnt - CW'(1));
                            buf_dout_nx = rd_data_c;
                        end
                        hold_vld_nx = 1'b0;
                        dma_addr_nx = dma_addr + AW'(1);
                        cnt_nx      = cnt + CW'(1);
                        if (cnt == CNT_LAST) state_nx = LAST;
                    end
                end
                LAST: begin
                    if (busak_n) begin
                        if (!hold_vld) begin
                            hold_q_nx   = dma_din;
                            hold_vld_nx = 1'b1;
                        end
                    end else begin
                        buf_we_nx   = 1'b1;
                        buf_addr_nx = BUF_LAST;
                        buf_dout_nx = rd_data_c;
                        hold_vld_nx = 1'b0;
                        busrq_nx    = 1'b0;
                        state_nx    = REL;
                    end
                end
                REL: begin
                    // A queued start keeps busy high straight into the next run.
                    if (busak_n) begin
                        busy_nx  = pending | dma_go;
                        state_nx = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Registered datapath and outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending  <= 1'b0;
            busrq    <= 1'b0;
            busy     <= 1'b0;
            buf_we   <= 1'b0;
            cnt      <= '0;
            dma_addr <= SRC_START;
            buf_addr <= '0;
            buf_dout <= '0;
            hold_q   <= '0;
            hold_vld <= 1'b0;
        end else begin
            pending  <= pending_nx;
            busrq    <= busrq_nx;
            busy     <= busy_nx;
            buf_we   <= buf_we_nx;
            cnt      <= cnt_nx;
            dma_addr <= dma_addr_nx;
            buf_addr <= buf_addr_nx;
            buf_dout <= buf_dout_nx;
            hold_q   <= hold_q_nx;
            hold_vld <= hold_vld_nx;
        end
    end

endmodule

// File: tb/tb_jtpang_objdma.sv
// Bench for jtpang_objdma: three instances (LEN=512, LEN=1, LEN=4096),
// one selected at a time by sel; source RAM byte = addr[7:0]^8'h5A.
module tb_jtpang_objdma;

    logic clk, rst, cen, go, ak, clr;
    logic [1:0] sel;
    int total, bad;

    logic go0, go1, go2, ak0, ak1, ak2;
    logic busrq0, busrq1, busrq2, we0, we1, we2, busy0, busy1, busy2, err0, err1, err2;
    logic [11:0] da0, da1, da2, ba0, ba1, ba2;
    logic [7:0]  q0, q1, q2, bd0, bd1, bd2;

    assign go0 = go & (sel == 2'd0);
    assign go1 = go & (sel == 2'd1);
    assign go2 = go & (sel == 2'd2);
    assign ak0 = (sel == 2'd0) ? ak : 1'b1;
    assign ak1 = (sel == 2'd1) ? ak : 1'b1;
    assign ak2 = (sel == 2'd2) ? ak : 1'b1;

    jtpang_objdma #(.AW(12), .LEN(512), .SRC_BASE(0)) u_dut (
        .clk(clk), .rst(rst), .cen(cen), .dma_go(go0), .busak_n(ak0), .busrq(busrq0),
        .dma_addr(da0), .dma_din(q0), .buf_addr(ba0), .buf_dout(bd0), .buf_we(we0),
        .busy(busy0), .dma_err(err0));
    jtpang_objdma #(.AW(12), .LEN(1), .SRC_BASE(0)) u_one (
        .clk(clk), .rst(rst), .cen(cen), .dma_go(go1), .busak_n(ak1), .busrq(busrq1),
        .dma_addr(da1), .dma_din(q1), .buf_addr(ba1), .buf_dout(bd1), .buf_we(we1),
        .busy(busy1), .dma_err(err1));
    jtpang_objdma #(.AW(12), .LEN(4096), .SRC_BASE(0)) u_big (
        .clk(clk), .rst(rst), .cen(cen), .dma_go(go2), .busak_n(ak2), .busrq(busrq2),
        .dma_addr(da2), .dma_din(q2), .buf_addr(ba2), .buf_dout(bd2), .buf_we(we2),
        .busy(busy2), .dma_err(err2));

    // Source RAMs: registered read on cen.
    always @(posedge clk) begin
        if (cen) begin
            q0 <= da0[7:0] ^ 8'h5A;
            q1 <= da1[7:0] ^ 8'h5A;
            q2 <= da2[7:0] ^ 8'h5A;
        end
    end

    // Write monitors: count, order and data errors per instance.
    int wc0, oe0, de0, wc1, oe1, de1, wc2, oe2, de2;
    logic [11:0] nx0, nx2;
    always @(posedge clk) begin
        if (rst || clr) begin
            wc0 <= 0; oe0 <= 0; de0 <= 0; nx0 <= 12'd0;
        end else if (we0) begin
            wc0 <= wc0 + 1;
            if (ba0 != nx0) oe0 <= oe0 + 1;
            if (bd0 != (ba0[7:0] ^ 8'h5A)) de0 <= de0 + 1;
            nx0 <= (nx0 == 12'd511) ? 12'd0 : nx0 + 12'd1;
        end
    end
    always @(posedge clk) begin
        if (rst || clr) begin
            wc1 <= 0; oe1 <= 0; de1 <= 0;
        end else if (we1) begin
            wc1 <= wc1 + 1;
            if (ba1 != 12'd0) oe1 <= oe1 + 1;
            if (bd1 != 8'h5A) de1 <= de1 + 1;
        end
    end
    always @(posedge clk) begin
        if (rst || clr) begin
            wc2 <= 0; oe2 <= 0; de2 <= 0; nx2 <= 12'd0;
        end else if (we2) begin
            wc2 <= wc2 + 1;
            if (ba2 != nx2) oe2 <= oe2 + 1;
            if (bd2 != (ba2[7:0] ^ 8'h5A)) de2 <= de2 + 1;
            nx2 <= nx2 + 12'd1;
        end
    end

    logic busrq_s, busy_s, we_s, err_s;
    logic [11:0] da_s, ba_s;
    logic [7:0]  bd_s;
    int wc_s, oe_s, de_s;
    always_comb begin
        case (sel)
            2'd0: begin busrq_s = busrq0; busy_s = busy0; we_s = we0; err_s = err0;
                        da_s = da0; ba_s = ba0; bd_s = bd0; wc_s = wc0; oe_s = oe0; de_s = de0; end
            2'd1: begin busrq_s = busrq1; busy_s = busy1; we_s = we1; err_s = err1;
                        da_s = da1; ba_s = ba1; bd_s = bd1; wc_s = wc1; oe_s = oe1; de_s = de1; end
            default: begin busrq_s = busrq2; busy_s = busy2; we_s = we2; err_s = err2;
                        da_s = da2; ba_s = ba2; bd_s = bd2; wc_s = wc2; oe_s = oe2; de_s = de2; end
        endcase
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // cen: one clk in four.
    initial begin
        int ph;
        ph = 0;
        cen = 1'b0;
        forever begin
            @(negedge clk);
            cen = (ph == 3);
            ph = (ph + 1) % 4;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic next_tick();
        do @(posedge clk); while (!cen);
        #1;
    endtask

    task automatic pulse_go();
        go = 1'b1;
        @(posedge clk);
        #1;
        go = 1'b0;
    endtask

    task automatic clear_mon();
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while (busy_s && w < 50) begin next_tick(); w++; end
        chk("idle", int'(busy_s), 0);
    endtask

    // Waits for busrq, grants after gdelay ticks, runs until busrq drops.
    // n = ticks after the grant tick until busrq is seen low.
    task automatic do_xfer(input int gdelay, input int stall_at, input int stall_len,
                           input int abort_at, input bit ovl,
                           output int n, output int frz_bad, output int stall_we);
        int w;
        logic [11:0] a0, b0;
        n = 0; frz_bad = 0; stall_we = 0; a0 = '0; b0 = '0;
        w = 0;
        while (!busrq_s && w < 20) begin next_tick(); w++; end
        chk("req_seen", int'(busrq_s), 1);
        repeat (gdelay) next_tick();
        ak = 1'b0;
        next_tick();
        while (busrq_s && n < 5000 && n != abort_at) begin
            next_tick();
            n++;
            if (stall_len > 0 && n == stall_at) begin
                ak = 1'b1; a0 = da_s; b0 = ba_s;
            end
            if (stall_len > 0 && n > stall_at && n <= stall_at + stall_len && we_s)
                stall_we++;
            if (stall_len > 0 && n == stall_at + stall_len) begin
                ak = 1'b0;
                if (da_s != a0 || ba_s != b0) frz_bad++;
            end
            if (ovl && (n == 10 || n == 20 || n == 30)) pulse_go();
        end
        if (n != abort_at) ak = 1'b1;
    endtask

    typedef struct {
        int gdelay;
        int stall_at;
        int stall_len;
        int exp_n;
        int exp_wr;
    } vec_t;

    initial begin
        vec_t vt[4];
        int n, fb, sw, gap, hi;
        total = 0; bad = 0;
        rst = 1'b1; go = 1'b0; ak = 1'b1; clr = 1'b0; sel = 2'd0;

        vt[0] = '{3,   0, 0, 513, 512};
        vt[1] = '{3, 100, 5, 518, 512};
        vt[2] = '{0,   1, 2, 515, 512};
        vt[3] = '{1, 512, 2, 515, 512};

        repeat (6) @(posedge clk);
        #1;
        chk("rst_busrq", int'(busrq_s), 0);
        chk("rst_busy", int'(busy_s), 0);
        chk("rst_we", int'(we_s), 0);
        chk("rst_dma_addr", int'(da_s), 0);
        chk("rst_buf_addr", int'(ba_s), 0);
        chk("rst_buf_dout", int'(bd_s), 0);
        chk("rst_err", int'(err_s), 0);
        rst = 1'b0;
        next_tick();

        // Table-driven transfers on the LEN=512 instance.
        for (int i = 0; i < 4; i++) begin
            clear_mon();
            pulse_go();
            do_xfer(vt[i].gdelay, vt[i].stall_at, vt[i].stall_len, -1, 1'b0, n, fb, sw);
            chk($sformatf("v%0d_rel_ticks", i), n, vt[i].exp_n);
            wait_idle();
            chk($sformatf("v%0d_writes", i), wc_s, vt[i].exp_wr);
            chk($sformatf("v%0d_order", i), oe_s, 0);
            chk($sformatf("v%0d_data", i), de_s, 0);
            if (vt[i].stall_len > 0) begin
                chk($sformatf("v%0d_frozen", i), fb, 0);
                chk($sformatf("v%0d_stall_we", i), sw, 0);
            end
        end

        // Overlapping starts: pulses at ticks 10/20/30 give one extra transfer.
        clear_mon();
        pulse_go();
        do_xfer(0, 0, 0, -1, 1'b1, n, fb, sw);
        chk("ovl_first_rel", n, 513);
        gap = 0; n = 0;
        while (!busrq_s && n < 20) begin
            next_tick(); n++;
            if (!busy_s) gap++;
        end
        chk("ovl_busy_gap", gap, 0);
        do_xfer(0, 0, 0, -1, 1'b0, n, fb, sw);
        chk("ovl_second_rel", n, 513);
        wait_idle();
        chk("ovl_writes", wc_s, 1024);
        chk("ovl_order", oe_s, 0);
        chk("ovl_data", de_s, 0);
        hi = 0;
        repeat (20) begin next_tick(); if (busrq_s) hi++; end
        chk("ovl_no_third", hi, 0);

        // Reset mid-transfer, then a clean transfer.
        clear_mon();
        pulse_go();
        do_xfer(0, 0, 0, 200, 1'b0, n, fb, sw);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busrq", int'(busrq_s), 0);
        chk("abort_we", int'(we_s), 0);
        chk("abort_busy", int'(busy_s), 0);
        rst = 1'b0; ak = 1'b1;
        next_tick();
        clear_mon();
        pulse_go();
        do_xfer(2, 0, 0, -1, 1'b0, n, fb, sw);
        chk("after_rst_rel", n, 513);
        wait_idle();
        chk("after_rst_writes", wc_s, 512);
        chk("after_rst_order", oe_s, 0);
        chk("after_rst_data", de_s, 0);

        // LEN=1.
        sel = 2'd1;
        clear_mon();
        pulse_go();
        do_xfer(2, 0, 0, -1, 1'b0, n, fb, sw);
        chk("len1_rel", n, 2);
        wait_idle();
        chk("len1_writes", wc_s, 1);
        chk("len1_addr", oe_s, 0);
        chk("len1_data", de_s, 0);

        // dma_go on the very clk where IDLE consumes pending must survive.
        clear_mon();
        next_tick();
        pulse_go();
        repeat (2) @(posedge clk);
        #1;
        go = 1'b1;
        @(posedge clk);
        #1;
        go = 1'b0;
        do_xfer(0, 0, 0, -1, 1'b0, n, fb, sw);
        do_xfer(0, 0, 0, -1, 1'b0, n, fb, sw);
        wait_idle();
        chk("samecyc_writes", wc_s, 2);
        chk("samecyc_data", de_s, 0);

        // LEN=4096: full address space, dma_addr wraps to SRC_BASE.
        sel = 2'd2;
        clear_mon();
        pulse_go();
        do_xfer(1, 0, 0, -1, 1'b0, n, fb, sw);
        chk("big_rel", n, 4097);
        chk("big_addr_wrap", int'(da_s), 0);
        wait_idle();
        chk("big_writes", wc_s, 4096);
        chk("big_order", oe_s, 0);
        chk("big_data", de_s, 0);
        chk("big_last_addr", int'(ba_s), 4095);

        // Grant never arrives.
        sel = 2'd1;
        clear_mon();
        pulse_go();
        n = 0;
        while (!busrq_s && n < 20) begin next_tick(); n++; end
        n = 0;
        while (busrq_s && n < 5000) begin next_tick(); n++; end
`ifdef JTPANG_DMA_WATCHDOG_EN
        chk("wdog_ticks", n, 1023);
        chk("wdog_err", int'(err_s), 1);
        chk("wdog_busy", int'(busy_s), 0);
        pulse_go();
        do_xfer(0, 0, 0, -1, 1'b0, n, fb, sw);
        wait_idle();
        chk("wdog_after_writes", wc_s, 1);
        chk("wdog_err_sticky", int'(err_s), 1);
`else
        chk("nowdog_ticks", n, 5000);
        chk("nowdog_busrq", int'(busrq_s), 1);
        chk("nowdog_err", int'(err_s), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
